// File: rtl/ah_snoop_fifo_pkg.sv
// Shared helpers for the snoopable FIFO: pointer wrap arithmetic that works
// for any depth, including depths that are not a power of two.
package ah_snoop_fifo_pkg;

   // Advance a pointer by one and wrap explicitly from depth-1 back to 0.
   function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
      return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/ah_snoop_cmp.sv
// Combinational content match: compares the snoop value against every
// occupied entry and OR-reduces the per-entry hits.
module ah_snoop_cmp
   import ah_snoop_fifo_pkg::*;
#(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 86
) (
   input  logic [DEPTH-1:0]        i_occ,
   input  logic [DEPTH*DATA_W-1:0] i_mem_flat,
   input  logic [DATA_W-1:0]       i_sdata,
   output logic                    o_hit
);

   logic [DEPTH-1:0] w_hits;

   // Only entries currently holding live data may match; stale words left
   // behind by a pop keep their value but lose their occupancy bit.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign w_hits[gi] = i_occ[gi] && (i_mem_flat[gi*DATA_W +: DATA_W] == i_sdata);
   end

   assign o_hit = |w_hits;

endmodule

// File: rtl/ah_snoop_fifo.sv
// Synchronous FIFO of any width/depth with a registered content-addressable
// snoop port, occupancy count and almost-full flag.
module ah_snoop_fifo
   import ah_snoop_fifo_pkg::*;
#(
   parameter  int DATA_W   = 10,
   parameter  int DEPTH    = 86,
   parameter  int AFULL_TH = 80,
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wvalid,
   output logic              wready,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   input  logic              rready,
   input  logic [DATA_W-1:0] sdata,
   input  logic              svalid,
   output logic              smatch,
   output logic              smatch_vld,
   output logic [CNT_W-1:0]  count,
   output logic              afull
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0]       r_mem [DEPTH];
   logic [DEPTH-1:0]        r_occ;
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]        r_count;
   logic                    r_smatch;
   logic                    r_smatch_vld;

   logic                    w_push;
   logic                    w_pop;
   logic [PTR_W-1:0]        w_wr_ptr_nxt;
   logic [PTR_W-1:0]        w_rd_ptr_nxt;
   logic [DEPTH*DATA_W-1:0] w_mem_flat;
   logic                    w_hit;

   // Handshake status depends only on registered occupancy, so a full FIFO
   // refuses a push even when a pop happens in the same cycle.
   assign wready = (r_count != CNT_W'(DEPTH));
   assign rvalid = (r_count != '0);
   assign w_push = wvalid && wready;
   assign w_pop  = rready && rvalid;

   assign w_wr_ptr_nxt = PTR_W'(ptr_inc(32'(r_wr_ptr), 32'(DEPTH)));
   assign w_rd_ptr_nxt = PTR_W'(ptr_inc(32'(r_rd_ptr), 32'(DEPTH)));

   assign rdata      = r_mem[r_rd_ptr];
   assign count      = r_count;
   assign afull      = (r_count >= CNT_W'(AFULL_TH));
   assign smatch     = r_smatch;
   assign smatch_vld = r_smatch_vld;

   // Storage write: load the entry under the write pointer on a push.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   // Occupancy bits: set on push, cleared on pop. Push and pop never target
   // the same entry in one cycle (equal pointers mean full or empty).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_occ <= '0;
      end else begin
         if (w_push) r_occ[r_wr_ptr] <= 1'b1;
         if (w_pop)  r_occ[r_rd_ptr] <= 1'b0;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
         if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign w_mem_flat[gi*DATA_W +: DATA_W] = r_mem[gi];
   end

   ah_snoop_cmp #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_cmp (
      .i_occ      (r_occ),
      .i_mem_flat (w_mem_flat),
      .i_sdata    (sdata),
      .o_hit      (w_hit)
   );

   // Snoop result register: compares use start-of-cycle state, so a word
   // being popped still hits and a word being pushed does not yet.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_smatch     <= 1'b0;
         r_smatch_vld <= 1'b0;
      end else begin
         r_smatch     <= svalid && w_hit;
         r_smatch_vld <= svalid;
      end
   end

endmodule

// File: tb/tb_ah_snoop_fifo.sv
// Directed, scoreboard-based bench for ah_snoop_fifo.
module tb_ah_snoop_fifo;

   localparam int DATA_W   = 10;
   localparam int DEPTH    = 86;
   localparam int AFULL_TH = 80;
   localparam int CNT_W    = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [DATA_W-1:0] wdata = '0;
   logic              wvalid = 1'b0;
   logic              wready;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              rready = 1'b0;
   logic [DATA_W-1:0] sdata = '0;
   logic              svalid = 1'b0;
   logic              smatch;
   logic              smatch_vld;
   logic [CNT_W-1:0]  count;
   logic              afull;

   int errors = 0;
   int checks = 0;
   logic [DATA_W-1:0] q[$];   // scoreboard: words expected in the FIFO, head first

   ah_snoop_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
      .clk(clk), .rstn(rstn), .wdata(wdata), .wvalid(wvalid), .wready(wready),
      .rdata(rdata), .rvalid(rvalid), .rready(rready), .sdata(sdata), .svalid(svalid),
      .smatch(smatch), .smatch_vld(smatch_vld), .count(count), .afull(afull)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every status output against the scoreboard state.
   task automatic chk_status(input string tag, input logic exp_hit, input logic exp_svld);
      chk({tag, "_count"},  32'(count),  32'(q.size()));
      chk({tag, "_rvalid"}, 32'(rvalid), 32'(q.size() != 0));
      chk({tag, "_wready"}, 32'(wready), 32'(q.size() != DEPTH));
      chk({tag, "_afull"},  32'(afull),  32'(q.size() >= AFULL_TH));
      chk({tag, "_smatch"}, 32'(smatch), 32'(exp_hit));
      chk({tag, "_svld"},   32'(smatch_vld), 32'(exp_svld));
      if (q.size() != 0) chk({tag, "_head"}, 32'(rdata), 32'(q[0]));
   endtask

   // One clock of stimulus; called 1 time unit after a rising edge.
   task automatic cycle(input string tag, input logic wv, input logic [DATA_W-1:0] wd,
                        input logic rr, input logic sv, input logic [DATA_W-1:0] sd);
      logic exp_hit;
      bit   do_push, do_pop;
      wvalid = wv; wdata = wd; rready = rr; svalid = sv; sdata = sd;
      exp_hit = 1'b0;
      if (sv) foreach (q[i]) if (q[i] == sd) exp_hit = 1'b1;
      do_push = wv && (q.size() != DEPTH);
      do_pop  = rr && (q.size() != 0);
      if (do_pop) begin
         chk({tag, "_pop"}, 32'(rdata), 32'(q[0]));
         $display("%s: pop %03h", tag, q[0]);
         void'(q.pop_front());
      end
      if (do_push) begin
         q.push_back(wd);
         $display("%s: push %03h", tag, wd);
      end
      @(posedge clk); #1;
      chk_status(tag, exp_hit, sv);
   endtask

   task automatic idle(input string tag);
      cycle(tag, 1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      int pushed;
      int guard;

      // Reset state
      #3;
      chk("rst_count",  32'(count),  32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_wready", 32'(wready), 32'd1);
      chk("rst_rdata",  32'(rdata),  32'd0);
      chk("rst_afull",  32'(afull),  32'd0);
      chk("rst_smvld",  32'(smatch_vld), 32'd0);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;

      // Snoop zero on empty FIFO: reset-zero memory must not match
      cycle("snoop_empty", 1'b0, '0, 1'b0, 1'b1, 10'h000);
      chk("snoop_empty_direct", 32'(smatch), 32'd0);

      // Basic push/pop
      cycle("basic", 1'b1, 10'h155, 1'b0, 1'b0, '0);
      cycle("basic", 1'b1, 10'h0AA, 1'b0, 1'b0, '0);
      chk("basic_cnt2", 32'(count), 32'd2);
      cycle("basic", 1'b0, '0, 1'b1, 1'b0, '0);
      cycle("basic", 1'b0, '0, 1'b1, 1'b0, '0);
      chk("basic_empty", 32'(rvalid), 32'd0);

      // Fill 0..85, overflow attempt, drain
      for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, DATA_W'(i), 1'b0, 1'b0, '0);
      chk("fill_full_wready", 32'(wready), 32'd0);
      chk("fill_full_count",  32'(count),  32'd86);
      cycle("fill_over", 1'b1, 10'h3AB, 1'b0, 1'b0, '0);
      for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0, '0);

      // Wrap with random stalls
      pushed = 0; guard = 0;
      while ((pushed < 200 || q.size() != 0) && guard < 5000) begin
         logic wv;
         wv = (pushed < 200) && ($urandom_range(0, 3) != 0);
         if (wv && q.size() != DEPTH) pushed++;
         cycle("wrap", wv, DATA_W'(pushed * 7 + 3), $urandom_range(0, 3) != 0, 1'b0, '0);
         guard++;
      end
      chk("wrap_done", 32'(guard < 5000), 32'd1);

      // Full with simultaneous push and pop
      for (int i = 0; i < DEPTH; i++) cycle("full2", 1'b1, DATA_W'(i + 100), 1'b0, 1'b0, '0);
      cycle("full_both", 1'b1, 10'h3CC, 1'b1, 1'b0, '0);
      chk("full_both_count", 32'(count), 32'd85);
      cycle("full_next", 1'b1, 10'h3CD, 1'b0, 1'b0, '0);
      for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, '0, 1'b1, 1'b0, '0);

      // Snoop basics
      cycle("snp", 1'b1, 10'h3FF, 1'b0, 1'b0, '0);
      cycle("snp", 1'b1, 10'h001, 1'b0, 1'b0, '0);
      cycle("snp_hit", 1'b0, '0, 1'b0, 1'b1, 10'h001);
      chk("snp_hit_direct", 32'(smatch), 32'd1);
      cycle("snp_miss", 1'b0, '0, 1'b0, 1'b1, 10'h002);
      cycle("snp_pop", 1'b0, '0, 1'b1, 1'b0, '0);
      cycle("snp_pop", 1'b0, '0, 1'b1, 1'b0, '0);
      cycle("snp_stale", 1'b0, '0, 1'b0, 1'b1, 10'h001);
      chk("snp_stale_direct", 32'(smatch), 32'd0);
      idle("snp_idle");

      // Same-cycle pop hit
      cycle("sc1", 1'b1, 10'h123, 1'b0, 1'b0, '0);
      cycle("sc1_pophit", 1'b1, 10'h321, 1'b1, 1'b1, 10'h123);
      chk("sc1_pophit_direct", 32'(smatch), 32'd1);
      cycle("sc1_pop", 1'b0, '0, 1'b1, 1'b0, '0);
      // Same-cycle push miss, then hit
      cycle("sc2", 1'b1, 10'h123, 1'b0, 1'b0, '0);
      cycle("sc2_pushmiss", 1'b1, 10'h321, 1'b1, 1'b1, 10'h321);
      chk("sc2_pushmiss_direct", 32'(smatch), 32'd0);
      cycle("sc2_rehit", 1'b0, '0, 1'b0, 1'b1, 10'h321);
      chk("sc2_rehit_direct", 32'(smatch), 32'd1);

      // Mid-operation reset with a snoop outstanding
      cycle("mid", 1'b1, 10'h055, 1'b0, 1'b1, 10'h321);
      #2 rstn = 1'b0;
      q.delete();
      #1;
      chk("mid_count",  32'(count),  32'd0);
      chk("mid_rvalid", 32'(rvalid), 32'd0);
      chk("mid_rdata",  32'(rdata),  32'd0);
      chk("mid_smatch", 32'(smatch), 32'd0);
      chk("mid_smvld",  32'(smatch_vld), 32'd0);
      wvalid = 1'b0; svalid = 1'b0; rready = 1'b0;
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      cycle("post_rst_snoop", 1'b0, '0, 1'b0, 1'b1, 10'h000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
